// File: rtl/sram_serial_ctrl.sv
// sram_serial_ctrl: serial-load SRAM front end with bit-serial word assembly,
// one-cycle write commit and a pipelined read path of RD_LAT cycles.
module sram_serial_ctrl #(
    parameter int ROWS      = 16,
    parameter int COLS      = 8,
    parameter int RD_LAT    = 1,
    parameter int MSB_FIRST = 1,
    localparam int AW       = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW       = $clog2(COLS + 1)
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            serial_in,
    input  logic            shift,
    input  logic            w_en,
    input  logic            r_en,
    input  logic [AW-1:0]   addr,
    output logic            word_ready,
    output logic            busy,
    output logic            data_valid,
    output logic [COLS-1:0] data_out,
    output logic            err
);
    typedef enum logic [1:0] {IDLE, LOAD, FULL, WRITE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [COLS-1:0]   shreg_q, shreg_d;
    logic [AW-1:0]     waddr_q, waddr_d;
    logic              err_q, err_d;
    logic              rd_ok;
    logic              addr_ok;
    logic [COLS-1:0]   shift_in;
    logic [COLS-1:0]   mem [ROWS];
    logic [RD_LAT-1:0] pv_q;
    logic [COLS-1:0]   pd_q [RD_LAT];

    assign addr_ok  = 32'(addr) < ROWS;
    assign shift_in = (MSB_FIRST != 0) ? {shreg_q[COLS-2:0], serial_in}
                                       : {serial_in, shreg_q[COLS-1:1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        waddr_d = waddr_q;
        err_d   = 1'b0;
        rd_ok   = 1'b0;
        case (state_q)
            IDLE, LOAD: begin
                if (shift) begin
                    shreg_d = shift_in;
                    cnt_d   = cnt_q + CW'(1);
                    state_d = (cnt_d == CW'(COLS)) ? FULL : LOAD;
                end
                err_d = w_en || (r_en && !addr_ok);
                rd_ok = r_en && addr_ok;
            end
            FULL: begin
                if (w_en && addr_ok) begin
                    state_d = WRITE;
                    waddr_d = addr;
                end
                // a write request wins over a simultaneous read, which is flagged
                err_d = shift || (w_en && !addr_ok) || (r_en && (w_en || !addr_ok));
                rd_ok = r_en && !w_en && addr_ok;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                shreg_d = '0;
                err_d   = shift || w_en || r_en;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            waddr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            waddr_q <= waddr_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == WRITE) mem[waddr_q] <= shreg_q;
    end

    // data stages only advance behind a valid token so data_out holds between pulses
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pv_q <= '0;
            for (int i = 0; i < RD_LAT; i++) pd_q[i] <= '0;
        end else begin
            pv_q[0] <= rd_ok;
            if (rd_ok) pd_q[0] <= mem[addr];
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                if (pv_q[i-1]) pd_q[i] <= pd_q[i-1];
            end
        end
    end

    assign word_ready = state_q == FULL;
    assign busy       = state_q == WRITE;
    assign err        = err_q;
    assign data_valid = pv_q[RD_LAT-1];
    assign data_out   = pd_q[RD_LAT-1];
endmodule
